// File: rtl/mem_multicycle_rd.sv
// mem_multicycle_rd: word-addressed main-memory model with a fixed read latency.
// It sits downstream of the cache fill FSMs. Writes complete in one cycle.
// Reads are non-pipelined and return data with a one-cycle data_valid pulse.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset (array contents are kept)
//   enable     request strobe, accepted when busy is low
//   wr         1 = write, 0 = read (qualified by enable)
//   addr       byte address; bit 0 is ignored and upper bits alias
//   data_in    write data
//   data_out   read data while data_valid is high, otherwise 0
//   data_valid one-cycle pulse marking returned read data
//   busy       read outstanding and not yet in its return cycle
module mem_multicycle_rd #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       data_in,
  output logic [15:0]       data_out,
  output logic              data_valid,
  output logic              busy
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = $clog2(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_e;

  state_e                state_q,  state_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [DATA_W-1:0]     hold_q,   hold_d;
  logic                  valid_q,  valid_d;
  logic                  busy_q,   busy_d;
  logic [DATA_W-1:0]     dout_q,   dout_d;

  logic [DATA_W-1:0]     mem_q [DEPTH_WORDS];
  logic [IDX_W-1:0]      idx;
  logic                  accept;
  logic                  unused_addr;

  // Word index drops the byte bit; upper bits alias.
  assign idx         = addr[IDX_W:1];
  assign unused_addr = ^{addr[ADDR_W-1:IDX_W+1], addr[0]};
  assign accept      = enable & ~busy_q;

  // Next-state: countdown in WAIT, then load on a newly accepted read.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;

    if (state_q == ST_WAIT) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        state_d = ST_IDLE;
      end
    end

    // A read accepted in the return cycle re-enters WAIT; data latched now.
    if (accept && !wr) begin
      state_d = ST_WAIT;
      cnt_d   = CNT_LOAD;
      hold_d  = mem_q[idx];
    end

    // Outputs are registered copies of the decode of the next state.
    valid_d = (state_d == ST_WAIT) && (cnt_d == '0);
    busy_d  = (state_d == ST_WAIT) && (cnt_d != '0);
    dout_d  = valid_d ? hold_d : '0;
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
    end
  end

  // Storage array; intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && accept && wr) begin
      mem_q[idx] <= data_in;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;

endmodule
